// File: rtl/sd_io_arbiter_pkg.sv
// Shared definitions for the SD sector-link arbiter.
// Holds the arbiter state encoding, the maximum requester count and a
// cyclic index-increment helper used for the round-robin pointer.
package sd_io_arbiter_pkg;

  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Next requester index after idx, wrapping nreq-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int nreq);
    if (int'(idx) >= nreq - 1) begin
      next_idx = {IDX_W{1'b0}};
    end else begin
      next_idx = idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/sd_io_arbiter_rr_picker.sv
// Cyclic priority encoder for the round-robin arbiter.
// Ports:
//   pending : per-requester request flags
//   rr_ptr  : index with highest priority this round
//   valid   : at least one request pending
//   idx     : first pending index at or after rr_ptr (cyclic)
module sd_io_arbiter_rr_picker
  import sd_io_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from lowest to highest priority so the last hit (closest to rr_ptr) wins.
  always_comb begin
    valid = |pending;
    idx   = {IDX_W{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NREQ]) begin
        idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter sharing one user_io SD-sector link between NREQ
// sd_card emulators. One grant covers one sector transfer; lba/rd/wr are
// registered towards user_io, ack and byte strobes are routed back to the
// granted requester only, and config bytes (io_din_strobe with io_ack low)
// are broadcast to every requester.
// Ports:
//   clk_sys, reset_n                 : clock, async active-low reset
//   req_rd/req_wr/req_lba/req_dout   : per-requester request, address, write byte
//   req_ack/req_din_strobe/
//   req_dout_strobe/req_err          : per-requester handshake back
//   io_lba/io_rd/io_wr/io_dout       : towards user_io
//   io_ack/io_din_strobe/
//   io_dout_strobe                   : from user_io
module sd_io_arbiter
  import sd_io_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_rd,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [32*NREQ-1:0]  req_lba,
  input  logic [8*NREQ-1:0]   req_dout,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     req_din_strobe,
  output logic [NREQ-1:0]     req_dout_strobe,
  output logic [NREQ-1:0]     req_err,
  output logic [31:0]         io_lba,
  output logic                io_rd,
  output logic                io_wr,
  input  logic                io_ack,
  input  logic                io_din_strobe,
  input  logic                io_dout_strobe,
  output logic [7:0]          io_dout
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_s;
  logic [IDX_W-1:0]       gnt_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [TIMEOUT_W-1:0]   cnt_r;
  logic [TIMEOUT_W-1:0]   cnt_inc_s;
  logic                   cnt_full_s;
  logic                   pick_valid_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [NREQ-1:0]        gnt_oh_s;
  logic                   active_s;

  sd_io_arbiter_rr_picker #(.NREQ(NREQ)) u_picker (
    .pending (req_rd | req_wr),
    .rr_ptr  (rr_ptr_r),
    .valid   (pick_valid_s),
    .idx     (pick_idx_s)
  );

  // The timeout fires on the ISSUE cycle whose increment reaches all-ones,
  // i.e. after 2**TIMEOUT_W - 1 cycles spent waiting for io_ack.
  assign cnt_inc_s  = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign cnt_full_s = &cnt_inc_s;
  assign gnt_oh_s   = ONE_HOT0 << gnt_r;
  assign active_s   = (state_r != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) state_s = ST_ISSUE;
        else              state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (io_ack)          state_s = ST_XFER;
        else if (cnt_full_s) state_s = ST_IDLE;
        else                 state_s = ST_ISSUE;
      end
      ST_XFER: begin
        if (!io_ack) state_s = ST_RELEASE;
        else         state_s = ST_XFER;
      end
      ST_RELEASE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Grant, link request registers, timeout counter and round-robin pointer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      gnt_r    <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      cnt_r    <= {TIMEOUT_W{1'b0}};
      io_lba   <= 32'h0000_0000;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      req_err  <= {NREQ{1'b0}};
    end else begin
      req_err <= {NREQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            gnt_r  <= pick_idx_s;
            io_lba <= req_lba[32*pick_idx_s +: 32];
            io_rd  <= req_rd[pick_idx_s];
            // A read wins over a simultaneous write; the write stays pending.
            io_wr  <= req_wr[pick_idx_s] & ~req_rd[pick_idx_s];
            cnt_r  <= {TIMEOUT_W{1'b0}};
          end
        end
        ST_ISSUE: begin
          cnt_r <= cnt_inc_s;
          if (io_ack) begin
            io_rd <= 1'b0;
            io_wr <= 1'b0;
          end else if (cnt_full_s) begin
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            req_err  <= gnt_oh_s;
            rr_ptr_r <= next_idx(gnt_r, NREQ);
          end
        end
        ST_XFER: begin
          if (!io_ack) rr_ptr_r <= next_idx(gnt_r, NREQ);
        end
        ST_RELEASE: begin
          cnt_r <= {TIMEOUT_W{1'b0}};
        end
        default: begin
          cnt_r <= {TIMEOUT_W{1'b0}};
        end
      endcase
    end
  end

  // Routing of user_io handshakes back to the requesters.
  always_comb begin
    req_ack         = {NREQ{1'b0}};
    req_dout_strobe = {NREQ{1'b0}};
    req_din_strobe  = {NREQ{1'b0}};
    io_dout         = 8'hFF;

    if (io_ack && active_s) req_ack = gnt_oh_s;
    else                    req_ack = {NREQ{1'b0}};

    if (io_dout_strobe && (state_r == ST_XFER)) req_dout_strobe = gnt_oh_s;
    else                                         req_dout_strobe = {NREQ{1'b0}};

    // With io_ack low user_io is streaming CID/CSD/config bytes: broadcast.
    if (io_ack) begin
      if (io_din_strobe && active_s) req_din_strobe = gnt_oh_s;
      else                           req_din_strobe = {NREQ{1'b0}};
    end else begin
      if (io_din_strobe) req_din_strobe = {NREQ{1'b1}};
      else               req_din_strobe = {NREQ{1'b0}};
    end

    if ((state_r == ST_ISSUE) || (state_r == ST_XFER)) io_dout = req_dout[8*gnt_r +: 8];
    else                                               io_dout = 8'hFF;
  end

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Self-checking bench for sd_io_arbiter (NREQ=2, TIMEOUT_W=4).
// Expected grants come from a round-robin pointer kept at transaction level.
module tb_sd_io_arbiter;

  localparam int N  = 2;
  localparam int TO = 15;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req_rd = 2'b00;
  logic [1:0]   req_wr = 2'b00;
  logic [31:0]  lba_m  [0:1];
  logic [7:0]   dout_m [0:1];
  logic [63:0]  req_lba;
  logic [15:0]  req_dout;
  logic [1:0]   req_ack, req_din_strobe, req_dout_strobe, req_err;
  logic [31:0]  io_lba;
  logic         io_rd, io_wr;
  logic         io_ack = 1'b0;
  logic         io_din_strobe = 1'b0;
  logic         io_dout_strobe = 1'b0;
  logic [7:0]   io_dout;

  int n_assert = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  assign req_lba  = {lba_m[1], lba_m[0]};
  assign req_dout = {dout_m[1], dout_m[0]};

  sd_io_arbiter #(.NREQ(2), .TIMEOUT_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_dout(req_dout),
    .req_ack(req_ack), .req_din_strobe(req_din_strobe),
    .req_dout_strobe(req_dout_strobe), .req_err(req_err),
    .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr),
    .io_ack(io_ack), .io_din_strobe(io_din_strobe),
    .io_dout_strobe(io_dout_strobe), .io_dout(io_dout)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int pick(input logic [1:0] pend, input int ptr);
    pick = -1;
    for (int k = 0; k < N; k++)
      if (pick < 0 && pend[(ptr + k) % N]) pick = (ptr + k) % N;
  endfunction

  // One full sector transaction from IDLE; ack_delay >= TO means a timeout.
  task automatic run_txn(input int ack_delay, input int nbytes);
    int g;
    logic [1:0] oh;
    logic erd, ewr;
    int n;
    g = pick(req_rd | req_wr, m_ptr);
    if (g < 0) begin
      chk("txn_has_request", 32'd0, 32'd1);
      return;
    end
    oh  = 2'b01 << g;
    erd = req_rd[g];
    ewr = req_wr[g] & ~req_rd[g];
    chk("idle_rd", io_rd, 1'b0);
    chk("idle_ack", req_ack, 2'b00);
    chk("idle_dout", io_dout, 8'hFF);
    step();
    chk("grant_rd", io_rd, erd);
    chk("grant_wr", io_wr, ewr);
    chk("grant_lba", io_lba, lba_m[g]);
    chk("grant_dout", io_dout, dout_m[g]);
    chk("grant_err", req_err, 2'b00);
    n = (ack_delay >= TO) ? TO : ack_delay;
    for (int i = 0; i < n; i++) begin
      chk("issue_ack", req_ack, 2'b00);
      chk("issue_rd", io_rd, erd);
      step();
    end
    if (ack_delay >= TO) begin
      chk("timeout_rd", io_rd, 1'b0);
      chk("timeout_wr", io_wr, 1'b0);
      chk("timeout_err", req_err, oh);
      m_ptr = (g + 1) % N;
      if (erd) req_rd[g] = 1'b0;
      else     req_wr[g] = 1'b0;
      return;
    end
    io_ack = 1'b1;
    io_din_strobe = 1'b1;
    #1;
    chk("issue_req_ack", req_ack, oh);
    chk("issue_din_route", req_din_strobe, oh);
    io_din_strobe = 1'b0;
    step();
    chk("xfer_rd", io_rd, 1'b0);
    chk("xfer_wr", io_wr, 1'b0);
    chk("xfer_ack", req_ack, oh);
    for (int b = 0; b < nbytes; b++) begin
      dout_m[g] = 8'($urandom);
      io_dout_strobe = 1'b1;
      #1;
      chk("xfer_dout_strobe", req_dout_strobe, oh);
      chk("xfer_dout", io_dout, dout_m[g]);
      step();
    end
    io_dout_strobe = 1'b0;
    if (erd) req_rd[g] = 1'b0;
    else     req_wr[g] = 1'b0;
    io_ack = 1'b0;
    #1;
    chk("ack_fall", req_ack, 2'b00);
    step();
    m_ptr = (g + 1) % N;
    chk("release_dout", io_dout, 8'hFF);
    step();
  endtask

  initial begin
    lba_m[0] = 32'h0; lba_m[1] = 32'h0;
    dout_m[0] = 8'h00; dout_m[1] = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_rd", io_rd, 1'b0);
    chk("rst_wr", io_wr, 1'b0);
    chk("rst_lba", io_lba, 32'h0);
    chk("rst_ack", req_ack, 2'b00);
    chk("rst_err", req_err, 2'b00);
    chk("rst_dout", io_dout, 8'hFF);
    reset_n = 1'b1;
    step();

    // Contention from reset: 0 then 1, pointer wraps back to 0.
    lba_m[0] = 32'hAAAA_0000; lba_m[1] = 32'hBBBB_1111;
    req_rd = 2'b11;
    run_txn(2, 2);
    run_txn(0, 1);
    chk("contention_ptr", m_ptr, 0);

    // Single read on requester 0.
    lba_m[0] = 32'h0000_1234;
    req_rd = 2'b01;
    run_txn(1, 3);

    // Config broadcast while idle, then stray io_ack while idle.
    for (int i = 0; i < 33; i++) begin
      io_din_strobe = 1'b1;
      #1;
      chk("cfg_broadcast", req_din_strobe, 2'b11);
      chk("cfg_no_rd", io_rd | io_wr, 1'b0);
      step();
      io_din_strobe = 1'b0;
      step();
    end
    io_ack = 1'b1;
    step();
    io_din_strobe = 1'b1;
    #1;
    chk("stray_ack", req_ack, 2'b00);
    chk("stray_din", req_din_strobe, 2'b00);
    chk("stray_rd", io_rd, 1'b0);
    io_ack = 1'b0;
    io_din_strobe = 1'b0;
    step();

    // 514-byte write on requester 1.
    lba_m[1] = 32'h0BAD_F00D;
    req_wr = 2'b10;
    run_txn(3, 514);

    // Timeout on requester 1 read.
    lba_m[1] = 32'h0000_7777;
    req_rd = 2'b10;
    run_txn(TO + 5, 0);
    step();
    chk("timeout_err_clear", req_err, 2'b00);
    chk("timeout_idle_rd", io_rd, 1'b0);

    // Move pointer to 1, then reset in the middle of a transfer.
    req_rd = 2'b01;
    run_txn(0, 0);
    chk("pre_reset_ptr", m_ptr, 1);
    lba_m[0] = 32'h1111_0000; lba_m[1] = 32'h2222_0001;
    req_rd = 2'b11;
    step();
    chk("rst_test_lba", io_lba, lba_m[pick(2'b11, m_ptr)]);
    io_ack = 1'b1;
    step();
    io_dout_strobe = 1'b1;
    io_din_strobe = 1'b1;
    #1;
    chk("rst_test_strobe", req_dout_strobe, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("async_ack", req_ack, 2'b00);
    chk("async_dout_strobe", req_dout_strobe, 2'b00);
    chk("async_din_strobe", req_din_strobe, 2'b00);
    chk("async_lba", io_lba, 32'h0);
    chk("async_dout", io_dout, 8'hFF);
    io_ack = 1'b0;
    io_dout_strobe = 1'b0;
    io_din_strobe = 1'b0;
    step();
    reset_n = 1'b1;
    m_ptr = 0;
    run_txn(1, 1);
    run_txn(0, 1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_rd[i] | req_wr[i]) && $urandom_range(0, 1) == 1) begin
          lba_m[i]  = $urandom;
          req_rd[i] = 1'($urandom_range(0, 1));
          req_wr[i] = 1'($urandom_range(0, 1));
        end
      end
      if ((req_rd | req_wr) == 2'b00) begin
        lba_m[it % N] = $urandom;
        req_wr[it % N] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0)
        run_txn(TO + int'($urandom_range(0, 3)), 0);
      else
        run_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
